// File: rtl/dq_pkg.sv
// Dispatch queue shared types: packed payload, operand record, core widths.
package dq_pkg;
    localparam int XLEN               = 32;
    localparam int PHY_REG_ADDR_WIDTH = 6;
    localparam int ROB_INDEX_WIDTH    = 6;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob_id;
        logic [XLEN-1:0]               pc;
        logic [XLEN-1:0]               imm;
        logic [2:0]                    func3;
        logic [1:0]                    fu_sel;
        logic                          is_load;
        logic                          is_store;
        logic                          is_fence;
        logic                          is_aext;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    } dq_payload_t;

    localparam int DQ_PAYLOAD_W = $bits(dq_payload_t);

    typedef struct packed {
        logic                          used;
        logic                          ready;
        logic [PHY_REG_ADDR_WIDTH-1:0] tag;
        logic [XLEN-1:0]               data;
    } dq_operand_t;
endpackage

// File: rtl/dq_wakeup.sv
// Per-operand writeback snoop: tag compare against alu1/alu2/lsu, alu1 wins.
module dq_wakeup
    import dq_pkg::*;
(
    input  logic                          used_i,
    input  logic                          ready_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] tag_i,
    input  logic                          alu1_v_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu1_prd_i,
    input  logic [XLEN-1:0]               alu1_data_i,
    input  logic                          alu2_v_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu2_prd_i,
    input  logic [XLEN-1:0]               alu2_data_i,
    input  logic                          lsu_v_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsu_prd_i,
    input  logic [XLEN-1:0]               lsu_data_i,
    output logic                          hit_o,
    output logic [XLEN-1:0]               data_o
);
    // Only a used, still-waiting operand can be woken; fixed port priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (used_i && !ready_i) begin
            if (alu1_v_i && alu1_prd_i == tag_i) begin
                hit_o  = 1'b1;
                data_o = alu1_data_i;
            end else if (alu2_v_i && alu2_prd_i == tag_i) begin
                hit_o  = 1'b1;
                data_o = alu2_data_i;
            end else if (lsu_v_i && lsu_prd_i == tag_i) begin
                hit_o  = 1'b1;
                data_o = lsu_data_i;
            end
        end
    end
endmodule

// File: rtl/dispatch_queue.sv
// Dual-issue in-order dispatch FIFO with writeback snooping on queued operands.
module dispatch_queue
    import dq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = DQ_PAYLOAD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          enq1_valid_i,
    input  logic                          enq2_valid_i,
    input  logic [PAYLOAD_W-1:0]          enq1_payload_i,
    input  logic [PAYLOAD_W-1:0]          enq2_payload_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] enq1_prs1_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] enq1_prs2_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] enq2_prs1_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] enq2_prs2_i,
    input  logic                          enq1_rs1_use_i,
    input  logic                          enq1_rs2_use_i,
    input  logic                          enq2_rs1_use_i,
    input  logic                          enq2_rs2_use_i,
    input  logic                          enq1_rs1_ready_i,
    input  logic                          enq1_rs2_ready_i,
    input  logic                          enq2_rs1_ready_i,
    input  logic                          enq2_rs2_ready_i,
    input  logic [XLEN-1:0]               enq1_data1_i,
    input  logic [XLEN-1:0]               enq1_data2_i,
    input  logic [XLEN-1:0]               enq2_data1_i,
    input  logic [XLEN-1:0]               enq2_data2_i,
    output logic                          enq_ready_first_o,
    output logic                          enq_ready_second_o,
    output logic                          instr1_valid_o,
    output logic                          instr2_valid_o,
    output logic [PAYLOAD_W-1:0]          instr1_payload_o,
    output logic [PAYLOAD_W-1:0]          instr2_payload_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] instr1_prs1_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] instr1_prs2_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] instr2_prs1_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] instr2_prs2_o,
    output logic                          instr1_rs1_use_o,
    output logic                          instr1_rs2_use_o,
    output logic                          instr2_rs1_use_o,
    output logic                          instr2_rs2_use_o,
    output logic                          instr1_rs1_ready_o,
    output logic                          instr1_rs2_ready_o,
    output logic                          instr2_rs1_ready_o,
    output logic                          instr2_rs2_ready_o,
    output logic [XLEN-1:0]               instr1_data1_o,
    output logic [XLEN-1:0]               instr1_data2_o,
    output logic [XLEN-1:0]               instr2_data1_o,
    output logic [XLEN-1:0]               instr2_data2_o,
    input  logic                          rs_ready_first_i,
    input  logic                          rs_ready_second_i,
    input  logic                          alu1_done_valid_i,
    input  logic                          alu2_done_valid_i,
    input  logic                          lsu_done_valid_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu1_wb_prd_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] alu2_wb_prd_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsu_wb_prd_i,
    input  logic [XLEN-1:0]               alu1_wb_data_i,
    input  logic [XLEN-1:0]               alu2_wb_data_i,
    input  logic [XLEN-1:0]               lsu_wb_data_i
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]        head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [AW:0]          count_q, count_d;
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    dq_operand_t          op1_q [DEPTH];
    dq_operand_t          op1_d [DEPTH];
    dq_operand_t          op2_q [DEPTH];
    dq_operand_t          op2_d [DEPTH];

    logic                 do_enq1, do_enq2, deq1, deq2;
    logic [1:0]           n_enq, n_deq;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);

    // Free-space flags use the registered count only; no dequeue credit.
    assign enq_ready_first_o  = count_q < (AW+1)'(DEPTH);
    assign enq_ready_second_o = count_q < (AW+1)'(DEPTH - 1);
    assign instr1_valid_o     = count_q != '0;
    assign instr2_valid_o     = count_q >= (AW+1)'(2);

    assign do_enq1 = enq1_valid_i && enq_ready_first_o && !flush_i;
    assign do_enq2 = do_enq1 && enq2_valid_i && enq_ready_second_o;
    assign deq1    = instr1_valid_o && rs_ready_first_i;
    assign deq2    = deq1 && instr2_valid_o && rs_ready_second_i;
    assign n_enq   = {1'b0, do_enq1} + {1'b0, do_enq2};
    assign n_deq   = {1'b0, deq1} + {1'b0, deq2};

    // Incoming operands: index 0/1 = enq1 rs1/rs2, 2/3 = enq2 rs1/rs2.
    logic [3:0]                    in_use, in_rdy, in_hit;
    logic [PHY_REG_ADDR_WIDTH-1:0] in_tag [4];
    logic [XLEN-1:0]               in_dat [4];
    logic [XLEN-1:0]               in_wd  [4];
    dq_operand_t                   enq_op [4];

    assign in_use = {enq2_rs2_use_i, enq2_rs1_use_i, enq1_rs2_use_i, enq1_rs1_use_i};
    assign in_rdy = {enq2_rs2_ready_i, enq2_rs1_ready_i, enq1_rs2_ready_i, enq1_rs1_ready_i};
    assign in_tag[0] = enq1_prs1_i;
    assign in_tag[1] = enq1_prs2_i;
    assign in_tag[2] = enq2_prs1_i;
    assign in_tag[3] = enq2_prs2_i;
    assign in_dat[0] = enq1_data1_i;
    assign in_dat[1] = enq1_data2_i;
    assign in_dat[2] = enq2_data1_i;
    assign in_dat[3] = enq2_data2_i;

    logic [DEPTH-1:0] e_hit1, e_hit2;
    logic [XLEN-1:0]  e_wd1 [DEPTH];
    logic [XLEN-1:0]  e_wd2 [DEPTH];

    for (genvar k = 0; k < 4; k++) begin : g_in_wk
        dq_wakeup u_wk (
            .used_i(in_use[k]), .ready_i(in_rdy[k]), .tag_i(in_tag[k]),
            .alu1_v_i(alu1_done_valid_i), .alu1_prd_i(alu1_wb_prd_i), .alu1_data_i(alu1_wb_data_i),
            .alu2_v_i(alu2_done_valid_i), .alu2_prd_i(alu2_wb_prd_i), .alu2_data_i(alu2_wb_data_i),
            .lsu_v_i(lsu_done_valid_i), .lsu_prd_i(lsu_wb_prd_i), .lsu_data_i(lsu_wb_data_i),
            .hit_o(in_hit[k]), .data_o(in_wd[k])
        );
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_wk
        dq_wakeup u_wk1 (
            .used_i(op1_q[i].used), .ready_i(op1_q[i].ready), .tag_i(op1_q[i].tag),
            .alu1_v_i(alu1_done_valid_i), .alu1_prd_i(alu1_wb_prd_i), .alu1_data_i(alu1_wb_data_i),
            .alu2_v_i(alu2_done_valid_i), .alu2_prd_i(alu2_wb_prd_i), .alu2_data_i(alu2_wb_data_i),
            .lsu_v_i(lsu_done_valid_i), .lsu_prd_i(lsu_wb_prd_i), .lsu_data_i(lsu_wb_data_i),
            .hit_o(e_hit1[i]), .data_o(e_wd1[i])
        );
        dq_wakeup u_wk2 (
            .used_i(op2_q[i].used), .ready_i(op2_q[i].ready), .tag_i(op2_q[i].tag),
            .alu1_v_i(alu1_done_valid_i), .alu1_prd_i(alu1_wb_prd_i), .alu1_data_i(alu1_wb_data_i),
            .alu2_v_i(alu2_done_valid_i), .alu2_prd_i(alu2_wb_prd_i), .alu2_data_i(alu2_wb_data_i),
            .lsu_v_i(lsu_done_valid_i), .lsu_prd_i(lsu_wb_prd_i), .lsu_data_i(lsu_wb_data_i),
            .hit_o(e_hit2[i]), .data_o(e_wd2[i])
        );
    end

    // Incoming operand resolution: unused operands count as ready.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            enq_op[k].used  = in_use[k];
            enq_op[k].ready = !in_use[k] || in_rdy[k] || in_hit[k];
            enq_op[k].tag   = in_tag[k];
            enq_op[k].data  = in_hit[k] ? in_wd[k] : in_dat[k];
        end
    end

    // Next state: wakeup, dequeue, enqueue; flush overrides pointers and valids.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        pay_d   = pay_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_hit1[i]) begin
                op1_d[i].ready = 1'b1;
                op1_d[i].data  = e_wd1[i];
            end
            if (e_hit2[i]) begin
                op2_d[i].ready = 1'b1;
                op2_d[i].data  = e_wd2[i];
            end
        end
        if (deq1) vld_d[head_q]  = 1'b0;
        if (deq2) vld_d[head_p1] = 1'b0;
        if (do_enq1) begin
            pay_d[tail_q] = enq1_payload_i;
            op1_d[tail_q] = enq_op[0];
            op2_d[tail_q] = enq_op[1];
            vld_d[tail_q] = 1'b1;
        end
        if (do_enq2) begin
            pay_d[tail_p1] = enq2_payload_i;
            op1_d[tail_p1] = enq_op[2];
            op2_d[tail_p1] = enq_op[3];
            vld_d[tail_p1] = 1'b1;
        end
        head_d  = head_q + AW'(n_deq);
        tail_d  = tail_q + AW'(n_enq);
        count_d = count_q + (AW+1)'(n_enq) - (AW+1)'(n_deq);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            vld_d   = '0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count/vld.
    always_ff @(posedge clk) begin
        pay_q <= pay_d;
        op1_q <= op1_d;
        op2_q <= op2_d;
    end

    assign instr1_payload_o   = pay_q[head_q];
    assign instr2_payload_o   = pay_q[head_p1];
    assign instr1_prs1_o      = op1_q[head_q].tag;
    assign instr1_prs2_o      = op2_q[head_q].tag;
    assign instr2_prs1_o      = op1_q[head_p1].tag;
    assign instr2_prs2_o      = op2_q[head_p1].tag;
    assign instr1_rs1_use_o   = op1_q[head_q].used;
    assign instr1_rs2_use_o   = op2_q[head_q].used;
    assign instr2_rs1_use_o   = op1_q[head_p1].used;
    assign instr2_rs2_use_o   = op2_q[head_p1].used;
    assign instr1_rs1_ready_o = op1_q[head_q].ready;
    assign instr1_rs2_ready_o = op2_q[head_q].ready;
    assign instr2_rs1_ready_o = op1_q[head_p1].ready;
    assign instr2_rs2_ready_o = op2_q[head_p1].ready;
    assign instr1_data1_o     = op1_q[head_q].data;
    assign instr1_data2_o     = op2_q[head_q].data;
    assign instr2_data1_o     = op1_q[head_p1].data;
    assign instr2_data2_o     = op2_q[head_p1].data;

    a_enq_room:  assert property (@(posedge clk) disable iff (!rst) enq1_valid_i |-> enq_ready_first_o);
    a_enq2_room: assert property (@(posedge clk) disable iff (!rst) (enq1_valid_i && enq2_valid_i) |-> enq_ready_second_o);
    a_enq2_lone: assert property (@(posedge clk) disable iff (!rst) enq2_valid_i |-> enq1_valid_i);
    a_head_vld:  assert property (@(posedge clk) disable iff (!rst) instr1_valid_o |-> vld_q[head_q]);
endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized + directed bench for dispatch_queue against a queue-based model.
module tb_dispatch_queue;
    import dq_pkg::*;
    localparam int DEPTH = 8;
    localparam int PW    = DQ_PAYLOAD_W;
    localparam int TW    = PHY_REG_ADDR_WIDTH;

    logic clk, rst, flush_i;
    logic enq1_valid_i, enq2_valid_i;
    logic [PW-1:0] enq1_payload_i, enq2_payload_i;
    logic [TW-1:0] enq1_prs1_i, enq1_prs2_i, enq2_prs1_i, enq2_prs2_i;
    logic enq1_rs1_use_i, enq1_rs2_use_i, enq2_rs1_use_i, enq2_rs2_use_i;
    logic enq1_rs1_ready_i, enq1_rs2_ready_i, enq2_rs1_ready_i, enq2_rs2_ready_i;
    logic [XLEN-1:0] enq1_data1_i, enq1_data2_i, enq2_data1_i, enq2_data2_i;
    logic enq_ready_first_o, enq_ready_second_o, instr1_valid_o, instr2_valid_o;
    logic [PW-1:0] instr1_payload_o, instr2_payload_o;
    logic [TW-1:0] instr1_prs1_o, instr1_prs2_o, instr2_prs1_o, instr2_prs2_o;
    logic instr1_rs1_use_o, instr1_rs2_use_o, instr2_rs1_use_o, instr2_rs2_use_o;
    logic instr1_rs1_ready_o, instr1_rs2_ready_o, instr2_rs1_ready_o, instr2_rs2_ready_o;
    logic [XLEN-1:0] instr1_data1_o, instr1_data2_o, instr2_data1_o, instr2_data2_o;
    logic rs_ready_first_i, rs_ready_second_i;
    logic alu1_done_valid_i, alu2_done_valid_i, lsu_done_valid_i;
    logic [TW-1:0] alu1_wb_prd_i, alu2_wb_prd_i, lsu_wb_prd_i;
    logic [XLEN-1:0] alu1_wb_data_i, alu2_wb_data_i, lsu_wb_data_i;

    dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .enq1_valid_i(enq1_valid_i), .enq2_valid_i(enq2_valid_i),
        .enq1_payload_i(enq1_payload_i), .enq2_payload_i(enq2_payload_i),
        .enq1_prs1_i(enq1_prs1_i), .enq1_prs2_i(enq1_prs2_i), .enq2_prs1_i(enq2_prs1_i), .enq2_prs2_i(enq2_prs2_i),
        .enq1_rs1_use_i(enq1_rs1_use_i), .enq1_rs2_use_i(enq1_rs2_use_i),
        .enq2_rs1_use_i(enq2_rs1_use_i), .enq2_rs2_use_i(enq2_rs2_use_i),
        .enq1_rs1_ready_i(enq1_rs1_ready_i), .enq1_rs2_ready_i(enq1_rs2_ready_i),
        .enq2_rs1_ready_i(enq2_rs1_ready_i), .enq2_rs2_ready_i(enq2_rs2_ready_i),
        .enq1_data1_i(enq1_data1_i), .enq1_data2_i(enq1_data2_i), .enq2_data1_i(enq2_data1_i), .enq2_data2_i(enq2_data2_i),
        .enq_ready_first_o(enq_ready_first_o), .enq_ready_second_o(enq_ready_second_o),
        .instr1_valid_o(instr1_valid_o), .instr2_valid_o(instr2_valid_o),
        .instr1_payload_o(instr1_payload_o), .instr2_payload_o(instr2_payload_o),
        .instr1_prs1_o(instr1_prs1_o), .instr1_prs2_o(instr1_prs2_o), .instr2_prs1_o(instr2_prs1_o), .instr2_prs2_o(instr2_prs2_o),
        .instr1_rs1_use_o(instr1_rs1_use_o), .instr1_rs2_use_o(instr1_rs2_use_o),
        .instr2_rs1_use_o(instr2_rs1_use_o), .instr2_rs2_use_o(instr2_rs2_use_o),
        .instr1_rs1_ready_o(instr1_rs1_ready_o), .instr1_rs2_ready_o(instr1_rs2_ready_o),
        .instr2_rs1_ready_o(instr2_rs1_ready_o), .instr2_rs2_ready_o(instr2_rs2_ready_o),
        .instr1_data1_o(instr1_data1_o), .instr1_data2_o(instr1_data2_o),
        .instr2_data1_o(instr2_data1_o), .instr2_data2_o(instr2_data2_o),
        .rs_ready_first_i(rs_ready_first_i), .rs_ready_second_i(rs_ready_second_i),
        .alu1_done_valid_i(alu1_done_valid_i), .alu2_done_valid_i(alu2_done_valid_i), .lsu_done_valid_i(lsu_done_valid_i),
        .alu1_wb_prd_i(alu1_wb_prd_i), .alu2_wb_prd_i(alu2_wb_prd_i), .lsu_wb_prd_i(lsu_wb_prd_i),
        .alu1_wb_data_i(alu1_wb_data_i), .alu2_wb_data_i(alu2_wb_data_i), .lsu_wb_data_i(lsu_wb_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]   pay;
        logic [TW-1:0]   t1, t2;
        logic            u1, u2, r1, r2;
        logic [XLEN-1:0] d1, d2;
    } ment_t;

    ment_t mq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Writeback snoop as stated: a waiting used operand takes the first matching port.
    function automatic logic [XLEN:0] wk(input logic u, input logic r, input logic [TW-1:0] t, input logic [XLEN-1:0] d);
        if (u && !r) begin
            if (alu1_done_valid_i && alu1_wb_prd_i == t) return {1'b1, alu1_wb_data_i};
            if (alu2_done_valid_i && alu2_wb_prd_i == t) return {1'b1, alu2_wb_data_i};
            if (lsu_done_valid_i && lsu_wb_prd_i == t)   return {1'b1, lsu_wb_data_i};
        end
        return {r, d};
    endfunction

    function automatic ment_t mk(input logic [PW-1:0] pay,
                                 input logic [TW-1:0] t1, input logic u1, input logic r1, input logic [XLEN-1:0] d1,
                                 input logic [TW-1:0] t2, input logic u2, input logic r2, input logic [XLEN-1:0] d2);
        ment_t e;
        logic [XLEN:0] w;
        e.pay = pay; e.t1 = t1; e.t2 = t2; e.u1 = u1; e.u2 = u2;
        w = wk(u1, r1, t1, d1); e.r1 = w[XLEN] | !u1; e.d1 = w[XLEN-1:0];
        w = wk(u2, r2, t2, d2); e.r2 = w[XLEN] | !u2; e.d2 = w[XLEN-1:0];
        return e;
    endfunction

    function automatic dq_payload_t rand_pay(input int rob);
        dq_payload_t p;
        p.rob_id   = ROB_INDEX_WIDTH'(rob);
        p.pc       = $urandom;
        p.imm      = $urandom;
        p.func3    = 3'($urandom);
        p.fu_sel   = 2'($urandom);
        p.is_load  = 1'($urandom);
        p.is_store = 1'($urandom);
        p.is_fence = 1'($urandom);
        p.is_aext  = 1'($urandom);
        p.prd      = TW'($urandom);
        return p;
    endfunction

    function automatic int rob_of(input logic [PW-1:0] v);
        dq_payload_t p;
        p = v;
        return int'(p.rob_id);
    endfunction

    task automatic idle();
        flush_i = 0; enq1_valid_i = 0; enq2_valid_i = 0;
        rs_ready_first_i = 0; rs_ready_second_i = 0;
        alu1_done_valid_i = 0; alu2_done_valid_i = 0; lsu_done_valid_i = 0;
        alu1_wb_prd_i = '0; alu2_wb_prd_i = '0; lsu_wb_prd_i = '0;
        alu1_wb_data_i = '0; alu2_wb_data_i = '0; lsu_wb_data_i = '0;
    endtask

    task automatic set_enq(input int slot, input int rob,
                           input int t1, input logic u1, input logic r1, input logic [XLEN-1:0] d1,
                           input int t2, input logic u2, input logic r2, input logic [XLEN-1:0] d2);
        if (slot == 1) begin
            enq1_valid_i = 1; enq1_payload_i = rand_pay(rob);
            enq1_prs1_i = TW'(t1); enq1_rs1_use_i = u1; enq1_rs1_ready_i = r1; enq1_data1_i = d1;
            enq1_prs2_i = TW'(t2); enq1_rs2_use_i = u2; enq1_rs2_ready_i = r2; enq1_data2_i = d2;
        end else begin
            enq2_valid_i = 1; enq2_payload_i = rand_pay(rob);
            enq2_prs1_i = TW'(t1); enq2_rs1_use_i = u1; enq2_rs1_ready_i = r1; enq2_data1_i = d1;
            enq2_prs2_i = TW'(t2); enq2_rs2_use_i = u2; enq2_rs2_ready_i = r2; enq2_data2_i = d2;
        end
    endtask

    task automatic chk_ent(input string p, input logic [PW-1:0] pay,
                           input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                           input logic u1, input logic u2, input logic r1, input logic r2,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input ment_t e);
        chk({p, "_pay"}, 128'(pay), 128'(e.pay));
        chk({p, "_prs1"}, 128'(t1), 128'(e.t1));
        chk({p, "_prs2"}, 128'(t2), 128'(e.t2));
        chk({p, "_use"}, 128'({u1, u2}), 128'({e.u1, e.u2}));
        chk({p, "_rdy"}, 128'({r1, r2}), 128'({e.r1, e.r2}));
        chk({p, "_d1"}, 128'(d1), 128'(e.d1));
        chk({p, "_d2"}, 128'(d2), 128'(e.d2));
    endtask

    // Compare registered outputs to the model, advance the model by one edge, then clock.
    task automatic tick();
        int n, nd;
        logic [XLEN:0] w;
        n = mq.size();
        chk("v1", 128'(instr1_valid_o), 128'(n >= 1));
        chk("v2", 128'(instr2_valid_o), 128'(n >= 2));
        chk("rdy1", 128'(enq_ready_first_o), 128'(n <= DEPTH - 1));
        chk("rdy2", 128'(enq_ready_second_o), 128'(n <= DEPTH - 2));
        if (n >= 1)
            chk_ent("i1", instr1_payload_o, instr1_prs1_o, instr1_prs2_o, instr1_rs1_use_o, instr1_rs2_use_o,
                    instr1_rs1_ready_o, instr1_rs2_ready_o, instr1_data1_o, instr1_data2_o, mq[0]);
        if (n >= 2)
            chk_ent("i2", instr2_payload_o, instr2_prs1_o, instr2_prs2_o, instr2_rs1_use_o, instr2_rs2_use_o,
                    instr2_rs1_ready_o, instr2_rs2_ready_o, instr2_data1_o, instr2_data2_o, mq[1]);
        if (!rst || flush_i) begin
            mq.delete();
        end else begin
            nd = 0;
            if (n >= 1 && rs_ready_first_i) nd = 1;
            if (nd == 1 && n >= 2 && rs_ready_second_i) nd = 2;
            foreach (mq[k]) begin
                w = wk(mq[k].u1, mq[k].r1, mq[k].t1, mq[k].d1); mq[k].r1 = w[XLEN]; mq[k].d1 = w[XLEN-1:0];
                w = wk(mq[k].u2, mq[k].r2, mq[k].t2, mq[k].d2); mq[k].r2 = w[XLEN]; mq[k].d2 = w[XLEN-1:0];
            end
            repeat (nd) void'(mq.pop_front());
            if (enq1_valid_i && n < DEPTH) begin
                mq.push_back(mk(enq1_payload_i, enq1_prs1_i, enq1_rs1_use_i, enq1_rs1_ready_i, enq1_data1_i,
                                enq1_prs2_i, enq1_rs2_use_i, enq1_rs2_ready_i, enq1_data2_i));
                if (enq2_valid_i && n < DEPTH - 1)
                    mq.push_back(mk(enq2_payload_i, enq2_prs1_i, enq2_rs1_use_i, enq2_rs1_ready_i, enq2_data1_i,
                                    enq2_prs2_i, enq2_rs2_use_i, enq2_rs2_ready_i, enq2_data2_i));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rob, pushed, cyc;
        rst = 0;
        idle();
        set_enq(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_enq(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        enq1_valid_i = 0; enq2_valid_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v1", 128'(instr1_valid_o), 128'(0));
        chk("rst_v2", 128'(instr2_valid_o), 128'(0));
        chk("rst_rdy1", 128'(enq_ready_first_o), 128'(1));
        chk("rst_rdy2", 128'(enq_ready_second_o), 128'(1));
        rst = 1;

        // Fill with robID 0..7, then pop pairs in order.
        for (int c = 0; c < 4; c++) begin
            idle();
            set_enq(1, 2*c, 1, 1, 1, 32'h100 + c, 2, 1, 1, 32'h200 + c);
            set_enq(2, 2*c+1, 3, 1, 1, 32'h300 + c, 4, 0, 0, 32'h400 + c);
            tick();
        end
        idle();
        chk("full_rdy1", 128'(enq_ready_first_o), 128'(0));
        rs_ready_first_i = 1; rs_ready_second_i = 1;
        tick();
        chk("pop_a1", 128'(rob_of(instr1_payload_o)), 128'(2));
        chk("pop_a2", 128'(rob_of(instr2_payload_o)), 128'(3));
        tick();
        chk("pop_b1", 128'(rob_of(instr1_payload_o)), 128'(4));
        tick(); tick();
        chk("drained", 128'(instr1_valid_o), 128'(0));

        // Partial pop: second-only pops nothing, first-only pops one.
        idle();
        set_enq(1, 10, 1, 0, 0, 1, 1, 0, 0, 2);
        set_enq(2, 11, 1, 0, 0, 1, 1, 0, 0, 2);
        tick();
        idle();
        set_enq(1, 12, 1, 0, 0, 1, 1, 0, 0, 2);
        tick();
        idle(); rs_ready_second_i = 1;
        tick();
        chk("pp_none", 128'(rob_of(instr1_payload_o)), 128'(10));
        idle(); rs_ready_first_i = 1;
        tick();
        chk("pp_one", 128'(rob_of(instr1_payload_o)), 128'(11));
        chk("pp_v2", 128'(instr2_valid_o), 128'(1));
        idle(); flush_i = 1;
        tick();

        // Stored-entry wakeup, then same-tag priority.
        idle();
        set_enq(1, 20, 17, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        set_enq(1, 21, 20, 1, 0, 0, 0, 0, 0, 0);
        alu2_done_valid_i = 1; alu2_wb_prd_i = 17; alu2_wb_data_i = 32'hDEAD;
        tick();
        chk("wk_rdy", 128'(instr1_rs1_ready_o), 128'(1));
        chk("wk_dat", 128'(instr1_data1_o), 128'(32'hDEAD));
        idle();
        alu1_done_valid_i = 1; alu1_wb_prd_i = 20; alu1_wb_data_i = 32'h1111;
        lsu_done_valid_i  = 1; lsu_wb_prd_i  = 20; lsu_wb_data_i  = 32'h3333;
        tick();
        chk("wk_pri", 128'(instr2_data1_o), 128'(32'h1111));
        idle(); flush_i = 1;
        tick();

        // Wakeup on the enqueue cycle.
        idle();
        set_enq(1, 22, 0, 0, 0, 0, 5, 1, 0, 0);
        lsu_done_valid_i = 1; lsu_wb_prd_i = 5; lsu_wb_data_i = 32'h42;
        tick();
        chk("eqw_rdy", 128'(instr1_rs2_ready_o), 128'(1));
        chk("eqw_dat", 128'(instr1_data2_o), 128'(32'h42));
        idle(); flush_i = 1;
        tick();

        // Random traffic: 3*DEPTH entries through with wraparound.
        rob = 30; pushed = 0; cyc = 0;
        while ((pushed < 3*DEPTH || mq.size() > 0) && cyc < 2000) begin
            idle();
            rs_ready_first_i  = 1'($urandom);
            rs_ready_second_i = 1'($urandom);
            alu1_done_valid_i = 1'($urandom); alu1_wb_prd_i = TW'($urandom_range(0, 7)); alu1_wb_data_i = $urandom;
            alu2_done_valid_i = 1'($urandom); alu2_wb_prd_i = TW'($urandom_range(0, 7)); alu2_wb_data_i = $urandom;
            lsu_done_valid_i  = 1'($urandom); lsu_wb_prd_i  = TW'($urandom_range(0, 7)); lsu_wb_data_i  = $urandom;
            if (pushed < 3*DEPTH && mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                set_enq(1, rob, $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom,
                        $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom);
                rob++; pushed++;
                if (pushed < 3*DEPTH && mq.size() < DEPTH - 1 && $urandom_range(0, 1) != 0) begin
                    set_enq(2, rob, $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom,
                            $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom);
                    rob++; pushed++;
                end
            end
            tick();
            cyc++;
        end
        chk("rnd_bound", 128'(cyc < 2000), 128'(1));
        idle();
        chk("rnd_empty", 128'(instr1_valid_o), 128'(0));

        // Flush with enqueue in the same cycle.
        set_enq(1, 50, 1, 1, 1, 7, 2, 1, 1, 8);
        set_enq(2, 51, 1, 1, 1, 7, 2, 1, 1, 8);
        tick();
        idle(); flush_i = 1; rs_ready_first_i = 1;
        set_enq(1, 52, 1, 1, 1, 7, 2, 1, 1, 8);
        tick();
        chk("fl_v1", 128'(instr1_valid_o), 128'(0));
        chk("fl_rdy2", 128'(enq_ready_second_o), 128'(1));
        idle();
        tick();
        chk("fl_drop", 128'(instr1_valid_o), 128'(0));

        // Reset in the middle of operation.
        set_enq(1, 53, 1, 1, 1, 7, 2, 1, 1, 8);
        set_enq(2, 54, 1, 1, 1, 7, 2, 1, 1, 8);
        tick();
        idle(); rst = 0;
        tick();
        chk("mrst_v1", 128'(instr1_valid_o), 128'(0));
        chk("mrst_rdy1", 128'(enq_ready_first_o), 128'(1));
        rst = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
